// File: rtl/letc_core_pipeline_ctrl.sv
// LETC core pipeline control: per-stage stall/flush from backpressure, redirects and a RAW scoreboard.
// Optional build macro LETC_CORE_FWD_EN: only load-use hazards in the first shadow entry stall issue.
module letc_core_pipeline_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int ISSUE_STAGE = 1,
    parameter int FLUSH_HOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stage_valid,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] redirect_req,
    input  logic [4:0]            issue_rs1,
    input  logic [4:0]            issue_rs2,
    input  logic                  issue_rs1_used,
    input  logic                  issue_rs2_used,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_rd_we,
    input  logic                  issue_is_load,
    output logic [NUM_STAGES-1:0] stage_stall,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  hazard_stall
);
    // Shadow entry j mirrors the instruction in stage ISSUE_STAGE+1+j.
    localparam int         NSH       = NUM_STAGES - 1 - ISSUE_STAGE;
    localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

    logic [NSH-1:0]  sh_vld_p1;
    logic [NSH-1:0]  sh_we_p1;
    logic [NSH-1:0]  sh_load_p1;
    logic [4:0]      sh_rd_p1 [NSH];
    logic [3:0]      hold_cnt_p1;

    logic [NSH-1:0]  src_vld;
    logic [NSH-1:0]  src_we;
    logic [NSH-1:0]  src_load;
    logic [4:0]      src_rd [NSH];

    logic [NUM_STAGES-1:0] redir_flush;
    logic [NUM_STAGES-1:0] flush_int;
    logic [NUM_STAGES-1:0] stall_int;
    logic                  redirect_any;
    logic [NSH-1:0]        hit;
    logic                  raw;
    logic                  hazard_int;
    logic                  unused_bits;

    function automatic logic src_hit(input logic [4:0] rs, input logic used, input logic [4:0] rd);
        return used && (rs != 5'd0) && (rs == rd);
    endfunction

    assign redirect_any = |redirect_req[NUM_STAGES-1:1];

    // Oldest requester wins: ascending scan lets the highest index overwrite the mask.
    always_comb begin
        redir_flush = '0;
        for (int s = 1; s < NUM_STAGES; s++) begin
            if (redirect_req[s]) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    redir_flush[k] = (k < s);
                end
            end
        end
        flush_int    = redir_flush;
        flush_int[0] = redir_flush[0] | (hold_cnt_p1 != 4'd0);
    end

    always_comb begin
        hit = '0;
        for (int j = 0; j < NSH; j++) begin
            hit[j] = sh_vld_p1[j] & sh_we_p1[j] &
                     (src_hit(issue_rs1, issue_rs1_used, sh_rd_p1[j]) |
                      src_hit(issue_rs2, issue_rs2_used, sh_rd_p1[j]));
        end
`ifdef LETC_CORE_FWD_EN
        raw = hit[0] & sh_load_p1[0];
`else
        raw = |hit;
`endif
        hazard_int = raw & stage_valid[ISSUE_STAGE] & ~flush_int[ISSUE_STAGE];
    end

    always_comb begin
        stall_int = '0;
        stall_int[NUM_STAGES-1] = stage_valid[NUM_STAGES-1] & ~stage_ready[NUM_STAGES-1];
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            stall_int[k] = stage_valid[k] & (~stage_ready[k] | stall_int[k+1]);
        end
        for (int k = 0; k <= ISSUE_STAGE; k++) begin
            stall_int[k] = stall_int[k] | hazard_int;
        end
        stall_int = stall_int & ~flush_int;
    end

    assign stage_stall  = stall_int & {NUM_STAGES{rst_n}};
    assign stage_flush  = flush_int & {NUM_STAGES{rst_n}};
    assign hazard_stall = hazard_int & rst_n;

    always_comb begin
        src_vld     = '0;
        src_we      = '0;
        src_load    = '0;
        src_vld[0]  = 1'b1;
        src_we[0]   = issue_rd_we;
        src_load[0] = issue_is_load;
        src_rd[0]   = issue_rd;
        for (int j = 1; j < NSH; j++) begin
            src_vld[j]  = sh_vld_p1[j-1];
            src_we[j]   = sh_we_p1[j-1];
            src_load[j] = sh_load_p1[j-1];
            src_rd[j]   = sh_rd_p1[j-1];
        end
    end

    // ---- issue -> shadow stage boundary: valid bits and hold counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_vld_p1   <= '0;
            hold_cnt_p1 <= 4'd0;
        end else begin
            for (int j = 0; j < NSH; j++) begin
                if (flush_int[ISSUE_STAGE+1+j]) begin
                    sh_vld_p1[j] <= 1'b0;
                end else if (stall_int[ISSUE_STAGE+1+j]) begin
                    sh_vld_p1[j] <= sh_vld_p1[j];
                end else if (stall_int[ISSUE_STAGE+j] | flush_int[ISSUE_STAGE+j] |
                             ~stage_valid[ISSUE_STAGE+j]) begin
                    sh_vld_p1[j] <= 1'b0;
                end else begin
                    sh_vld_p1[j] <= src_vld[j];
                end
            end
            if (redirect_any) begin
                hold_cnt_p1 <= HOLD_INIT;
            end else if (hold_cnt_p1 != 4'd0) begin
                hold_cnt_p1 <= hold_cnt_p1 - 4'd1;
            end
        end
    end

    // Payload is only meaningful under sh_vld_p1, so it advances whenever the stage is not held.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NSH; j++) begin
            if (!stall_int[ISSUE_STAGE+1+j]) begin
                sh_we_p1[j]   <= src_we[j];
                sh_load_p1[j] <= src_load[j];
                sh_rd_p1[j]   <= src_rd[j];
            end
        end
    end

    assign unused_bits = ^{redirect_req[0], sh_load_p1, hit};

endmodule

// File: doc/letc_core_pipeline_ctrl.md
# letc_core_pipeline_ctrl

Parametrised pipeline control unit for the LETC core: generates per-stage stall and flush from stage ready/valid status, redirect requests and a register-hazard scoreboard. It holds a shadow copy of each in-flight destination register past the issue stage, so it can detect RAW hazards at issue. It sits beside the core stages as the single owner of `stage_stall`/`stage_flush`. It generalises the fixed-depth glue to any stage count and issue position, and adds redirect-priority arbitration plus a post-redirect fetch flush hold.

## Interface
Parameters:
- `NUM_STAGES`, 5: pipeline depth; stage 0 = fetch, stage `NUM_STAGES-1` = writeback.
- `ISSUE_STAGE`, 1: stage that reads source registers; legal range 0 .. `NUM_STAGES-2`.
- `FLUSH_HOLD`, 1: extra cycles stage 0 stays flushed after a redirect; legal range 0..15.

Ports:
- `clk` in 1: core clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stage_valid` in `NUM_STAGES`: stage holds a valid instruction.
- `stage_ready` in `NUM_STAGES`: stage has finished its work this cycle.
- `redirect_req` in `NUM_STAGES`: bit s = stage s requests a redirect (branch/exception); bit 0 is ignored.
- `issue_rs1`, `issue_rs2` in 5 each: sources of the instruction in `ISSUE_STAGE`.
- `issue_rs1_used`, `issue_rs2_used` in 1 each: the corresponding source is read.
- `issue_rd` in 5, `issue_rd_we` in 1: destination of the issuing instruction.
- `issue_is_load` in 1: the issuing instruction is a load.
- `stage_stall` out `NUM_STAGES`: hold the stage's contents.
- `stage_flush` out `NUM_STAGES`: invalidate the stage's contents.
- `hazard_stall` out 1: a RAW hazard is holding `ISSUE_STAGE` this cycle.

## Operation
- **Redirect arbitration**
  - The winner is the highest set index s of `redirect_req` (the oldest instruction).
  - `stage_flush[k]` = 1 for all k < s, in the same cycle (combinational).
  - Stage s and later are never flushed by that redirect.
- **Flush hold**
  - A 4-bit counter loads `FLUSH_HOLD` on any redirect.
  - While the counter is nonzero: `stage_flush[0]` = 1 and the counter decrements.
  - A new redirect during the hold reloads the counter.
- **Backpressure**
  - `stage_stall[N-1]` = `valid & ~ready` of the last stage.
  - For k < N-1: `stall[k]` = `(valid[k] & ~ready[k]) | (valid[k] & stall[k+1])`.
  - An invalid stage never stalls; it accepts a bubble.
- **Hazard**
  - Shadow entries `{valid, rd_we, rd, is_load}` exist for stages `ISSUE_STAGE+1` .. `N-1`.
  - A hazard exists when a used source is nonzero and equals `rd` of a valid entry with `rd_we` set.
  - `hazard_stall` is gated by `stage_valid[ISSUE_STAGE]`.
  - A hazard forces `stage_stall[k]` = 1 for all k <= `ISSUE_STAGE`.
- **Flush priority**: flush overrides stall. `stage_stall[k]` = 0 whenever `stage_flush[k]` = 1.
- **Shadow update**, applied to entry k each cycle in priority order:
  1. `stage_flush[k]` set: clear the entry.
  2. `stall[k]` set: hold the entry.
  3. Previous stage stalled, flushed, or invalid: clear the entry (bubble).
  4. Otherwise: copy entry k-1. The entry at `ISSUE_STAGE+1` loads from the `issue_*` inputs.
- **Retire**: the last entry's contents are dropped when the last stage advances.
- **x0**: register 0 never creates a hazard.

## Timing
- Stall, flush and hazard outputs are combinational from inputs and current state, with zero latency.
- Shadow entries and the hold counter update on the rising edge of `clk`.
- Reset is asynchronous. While `rst_n` = 0:
  - all shadow entries are invalid and the hold counter is 0;
  - `stage_stall`, `stage_flush` and `hazard_stall` are all 0.
- The first edge after reset release is normal operation.
- Simultaneous redirect and hazard: the flush wins and the issue stage is not stalled that cycle.
- Reset asserted mid-redirect or mid-hold: the hold is abandoned immediately.

## Configuration
`LETC_CORE_FWD_EN`:
- **Defined** (forwarding present): a hazard is raised only for a match in entry `ISSUE_STAGE+1` whose `is_load` = 1 (load-use, one-cycle stall). Other matches are ignored.
- **Undefined**: any match in any shadow entry stalls. The `is_load` storage is still present but unused.

## Test plan
Defaults: N=5, issue stage 1.
- **Backpressure**: all stages valid, `stage_ready[3]`=0 -> `stage_stall`=5'b01111 and `stage_flush`=0.
- **Redirect priority**: `redirect_req`=5'b01100, `FLUSH_HOLD`=2 -> `stage_flush`=5'b00111 that cycle, then 5'b00001 for exactly 2 further cycles, then 0.
- **RAW, no FWD**:
  - Sequence: issue `addi x5`, then `add x6,x5,x5`.
  - Required: `hazard_stall`=1 for 3 cycles, until the `x5` entry leaves stage 4.
- **RAW, with `LETC_CORE_FWD_EN`**:
  - Load to `x7` then use of `x7` -> exactly 1 stall cycle.
  - ALU write to `x7` then use -> 0 stall cycles.
- **x0**: writer of `x0` followed by a reader of `x0` -> `hazard_stall` never asserted.
- **Reset mid-hazard**:
  - Drop `rst_n` while `hazard_stall`=1 -> all outputs 0 asynchronously.
  - After release, the same reader issues with no stall.
